// File: rtl/square_colour_ctrl.sv
// Pushbutton controller for the three-square colour display: synchronises buttons,
// applies one action per press with a lockout, and optionally detects a row match (SQUARE_MATCH_EN).
module square_colour_ctrl #(
    parameter int TICK_DIV      = 100000,
    parameter int LOCKOUT_TICKS = 200,
    parameter int NUM_COLOURS   = 6
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_centre,
    input  logic       btn_down,
    output logic [1:0] sel,
    output logic [2:0] colour0,
    output logic [2:0] colour1,
    output logic [2:0] colour2,
    output logic       match,
    output logic [2:0] match_colour,
    output logic       action
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(LOCKOUT_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOCKOUT_TICKS - 1);
    localparam logic [2:0]       MAX_COLOUR = 3'(NUM_COLOURS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sync_meta;
    logic [2:0]       sync_lvl;
    logic             s_up;
    logic             s_centre;
    logic             s_down;
    logic             any_btn;
    logic             tick;

    // Bit order {up, centre, down} through a two-flop synchroniser.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_lvl  <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync_lvl take the pre-edge sync_meta, giving a true two-stage chain.
            sync_meta <= {btn_up, btn_centre, btn_down};
            sync_lvl  <= sync_meta;
        end
    end

    assign s_up     = sync_lvl[2];
    assign s_centre = sync_lvl[1];
    assign s_down   = sync_lvl[0];
    assign any_btn  = s_up | s_centre | s_down;
    assign tick     = (div == DIV_LAST);

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == MAX_COLOUR) ? 3'd0 : c + 3'd1;
    endfunction

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div     <= '0;
            cnt     <= '0;
            sel     <= 2'd0;
            colour0 <= 3'd0;
            colour1 <= 3'd0;
            colour2 <= 3'd0;
            action  <= 1'b0;
        end else begin
            action <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_btn) begin
                        action <= 1'b1;
                        div    <= '0;
                        cnt    <= '0;
                        state  <= LOCK;
                        if (s_centre) begin
                            case (sel)
                                2'd0:    colour0 <= next_colour(colour0);
                                2'd1:    colour1 <= next_colour(colour1);
                                default: colour2 <= next_colour(colour2);
                            endcase
                        end else if (s_up) begin
                            sel <= (sel == 2'd0) ? 2'd2 : sel - 2'd1;
                        end else if (s_down) begin
                            sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                        end
                    end
                end
                LOCK: begin
                    if (tick) begin
                        div <= '0;
                        cnt <= cnt + CNT_W'(1);
                        // Leaving on the last tick makes LOCK exactly LOCKOUT_TICKS*TICK_DIV cycles long.
                        if (cnt == CNT_LAST) state <= WAIT_REL;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!any_btn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SQUARE_MATCH_EN
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            match        <= 1'b0;
            match_colour <= 3'd0;
        end else begin
            match        <= (colour0 == colour1) && (colour1 == colour2) && (colour0 != 3'd0);
            match_colour <= ((colour0 == colour1) && (colour1 == colour2)) ? colour0 : 3'd0;
        end
    end
`else
    assign match        = 1'b0;
    assign match_colour = 3'd0;
`endif

endmodule
